// File: rtl/pc_sequencer.sv
// Fetch/issue controller owning the PC: fetches from instruction memory, hands words to decode.
// Optional build macro PC_WRAP_TRAP_EN: a sequential PC carry-out traps and halts instead of wrapping.
module pc_sequencer #(
  parameter int unsigned     AW       = 8,
  parameter int unsigned     IW       = 32,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_data,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  input  logic          halt_req,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          trap
);

  typedef enum logic [1:0] {StIdle, StFetch, StIssue, StHalt} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          trap_q, trap_d;
  logic          issue_fire;

`ifdef PC_WRAP_TRAP_EN
  // Extra bit exposes the carry out of the sequential increment.
  logic [AW:0]   pc_inc;
  assign pc_inc = {1'b0, pc_q} + (AW+1)'(PC_STEP);
`else
  logic [AW-1:0] pc_inc;
  assign pc_inc = pc_q + AW'(PC_STEP);
`endif

  assign issue_fire = valid_q & instr_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    trap_d  = trap_q;
    unique case (state_q)
      StIdle: begin
        if (halt_req) begin
          state_d = StHalt;
        end else if (start) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (imem_ack) begin
          instr_d = imem_data;
          valid_d = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (issue_fire) begin
          valid_d = 1'b0;
          state_d = halt_req ? StHalt : StFetch;
          if (br_taken) begin
            pc_d = br_target;
          end else begin
`ifdef PC_WRAP_TRAP_EN
            if (pc_inc[AW]) begin
              trap_d  = 1'b1;
              state_d = StHalt;
            end else begin
              pc_d = pc_inc[AW-1:0];
            end
`else
            pc_d = pc_inc;
`endif
          end
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      trap_q  <= trap_d;
    end
  end

  assign imem_req    = (state_q == StFetch);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign busy        = (state_q == StFetch) || (state_q == StIssue);
  assign halted      = (state_q == StHalt);
  assign trap        = trap_q;

endmodule
